dll_fetcher: RTL and testbench

DLL_FETCHER -- requirements
Module: dll_fetcher

---
 rtl/dll_fetcher.sv | 157 +++++++++++++++
 tb/tb_dll_fetcher.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_fetcher.sv
// dll_fetcher: walks the MARIA display-list-list, fetching one 3-byte zone
// entry per zone and pacing the zones against scanline ends.
module dll_fetcher (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] ZP,
  input  logic        dma_en,
  input  logic        frame_start,
  input  logic        line_end,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [15:0] dl_ptr,
  output logic [3:0]  line_offset,
  output logic        holey16,
  output logic        holey8,
  output logic        dl_valid,
  output logic        dli_req,
  output logic        late_fetch
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_FETCH2 = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_dll_ptr;
  logic [7:0]  r_byte0;
  logic [7:0]  r_byte1;
  logic [15:0] r_dl_ptr;
  logic [3:0]  r_line_offset;
  logic        r_holey16;
  logic        r_holey8;
  logic        r_dli_bit;
  logic        r_dl_valid;
  logic        r_dli_req;
  logic        r_late_fetch;
  logic        r_line_pending;

  logic        w_ack;
  logic        w_apply;
  logic        w_unused_rsvd;

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Request and address come straight from the state, so an abort or DMA
  // disable removes the request in the very next cycle.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_addr     = 16'h0000;
    case (r_state)
      S_FETCH0: begin mem_req = 1'b1; mem_addr = r_dll_ptr;          end
      S_FETCH1: begin mem_req = 1'b1; mem_addr = r_dll_ptr + 16'd1;  end
      S_FETCH2: begin mem_req = 1'b1; mem_addr = r_dll_ptr + 16'd2;  end
      default:  ;
    endcase
    w_ack   = mem_req & mem_ack;
    w_apply = (r_state == S_WAIT) & (r_line_pending | line_end);

    if (!dma_en) begin
      w_next_state = S_IDLE;
    end else if (frame_start) begin
      w_next_state = S_FETCH0;
    end else begin
      case (r_state)
        S_FETCH0: if (w_ack) w_next_state = S_FETCH1;
        S_FETCH1: if (w_ack) w_next_state = S_FETCH2;
        S_FETCH2: if (w_ack) w_next_state = S_WAIT;
        S_WAIT:   if (w_apply && r_line_offset == 4'd0) w_next_state = S_FETCH0;
        default:  w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dll_ptr      <= 16'h0000;
      r_byte0        <= 8'h00;
      r_byte1        <= 8'h00;
      r_dl_ptr       <= 16'h0000;
      r_line_offset  <= 4'd0;
      r_holey16      <= 1'b0;
      r_holey8       <= 1'b0;
      r_dli_bit      <= 1'b0;
      r_dl_valid     <= 1'b0;
      r_dli_req      <= 1'b0;
      r_late_fetch   <= 1'b0;
      r_line_pending <= 1'b0;
    end else begin
      r_dl_valid <= 1'b0;
      r_dli_req  <= 1'b0;
      if (!dma_en) begin
        // DMA off: everything visible to the renderer is frozen.
      end else if (frame_start) begin
        r_dll_ptr      <= ZP;
        r_late_fetch   <= 1'b0;
        r_line_pending <= 1'b0;
      end else begin
        case (r_state)
          S_FETCH0, S_FETCH1, S_FETCH2: begin
            if (line_end) begin
              if (r_line_pending) r_late_fetch   <= 1'b1;
              else                r_line_pending <= 1'b1;
            end
            if (w_ack) begin
              if (r_state == S_FETCH0) r_byte0 <= mem_data;
              if (r_state == S_FETCH1) r_byte1 <= mem_data;
              if (r_state == S_FETCH2) begin
                r_dl_ptr      <= {r_byte1, mem_data};
                r_line_offset <= r_byte0[3:0];
                r_holey16     <= r_byte0[6];
                r_holey8      <= r_byte0[5];
                r_dli_bit     <= r_byte0[7];
                r_dl_valid    <= 1'b1;
                r_dli_req     <= r_byte0[7] & (r_byte0[3:0] == 4'd0);
                r_dll_ptr     <= r_dll_ptr + 16'd3;
              end
            end
          end
          S_WAIT: begin
            // A pending line and a fresh one together: consume one, keep one.
            if (w_apply) begin
              r_line_pending <= r_line_pending & line_end;
              if (r_line_offset != 4'd0) begin
                r_line_offset <= r_line_offset - 4'd1;
                if (r_line_offset == 4'd1 && r_dli_bit) r_dli_req <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_unused_rsvd = r_byte0[4];

  assign dl_ptr      = r_dl_ptr;
  assign line_offset = r_line_offset;
  assign holey16     = r_holey16;
  assign holey8      = r_holey8;
  assign dl_valid    = r_dl_valid;
  assign dli_req     = r_dli_req;
  assign late_fetch  = r_late_fetch;

endmodule

// File: tb/tb_dll_fetcher.sv
// Testbench for dll_fetcher: scoreboard of expected read addresses and
// expected zone loads, served by a small memory responder.
module tb_dll_fetcher;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] ZP;
  logic        dma_en;
  logic        frame_start;
  logic        line_end;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [15:0] dl_ptr;
  logic [3:0]  line_offset;
  logic        holey16;
  logic        holey8;
  logic        dl_valid;
  logic        dli_req;
  logic        late_fetch;

  typedef struct {
    logic [15:0] ptr;
    logic [3:0]  off;
    logic        h16;
    logic        h8;
    logic        dli;
  } load_t;

  logic [15:0] addrQ[$];
  load_t       loadQ[$];
  logic [15:0] lastAddr;
  int          checkCount = 0;
  int          errorCount = 0;

  dll_fetcher dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ZP         (ZP),
    .dma_en     (dma_en),
    .frame_start(frame_start),
    .line_end   (line_end),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .dl_ptr     (dl_ptr),
    .line_offset(line_offset),
    .holey16    (holey16),
    .holey8     (holey8),
    .dl_valid   (dl_valid),
    .dli_req    (dli_req),
    .late_fetch (late_fetch)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic fs, input logic le);
    frame_start = fs;
    line_end    = le;
    tick();
    frame_start = 1'b0;
    line_end    = 1'b0;
  endtask

  task automatic expectRequest();
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    checkOutput("reqSeen", {31'd0, mem_req}, 32'd1);
    checkOutput("addrQNonEmpty", {31'd0, addrQ.size() != 0}, 32'd1);
    if (addrQ.size() != 0) begin
      lastAddr = addrQ.pop_front();
      checkOutput("reqAddr", {16'd0, mem_addr}, {16'd0, lastAddr});
    end
  endtask

  task automatic serveRead(input logic [7:0] data, input int delay, input bit injectLe);
    expectRequest();
    for (int i = 0; i < delay; i++) begin
      line_end = injectLe && (i == 1 || i == 4);
      tick();
      line_end = 1'b0;
    end
    if (delay > 0) begin
      checkOutput("reqHold", {31'd0, mem_req}, 32'd1);
      checkOutput("addrHold", {16'd0, mem_addr}, {16'd0, lastAddr});
    end
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
    mem_data = 8'h00;
  endtask

  task automatic serveEntry(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int delay0, input bit injectLe);
    load_t exp;
    load_t got;
    exp.ptr = {b1, b2};
    exp.off = b0[3:0];
    exp.h16 = b0[6];
    exp.h8  = b0[5];
    exp.dli = b0[7] && (b0[3:0] == 4'd0);
    loadQ.push_back(exp);
    serveRead(b0, delay0, injectLe);
    serveRead(b1, 1, 1'b0);
    serveRead(b2, 0, 1'b0);
    checkOutput("dlValid", {31'd0, dl_valid}, 32'd1);
    checkOutput("reqAfterLoad", {31'd0, mem_req}, 32'd0);
    got = loadQ.pop_front();
    checkOutput("dlPtr", {16'd0, dl_ptr}, {16'd0, got.ptr});
    checkOutput("lineOffset", {28'd0, line_offset}, {28'd0, got.off});
    checkOutput("holey16", {31'd0, holey16}, {31'd0, got.h16});
    checkOutput("holey8", {31'd0, holey8}, {31'd0, got.h8});
    checkOutput("dliAtLoad", {31'd0, dli_req}, {31'd0, got.dli});
  endtask

  initial begin
    reset = 1'b1; ZP = 16'h0000; dma_en = 1'b0; frame_start = 1'b0;
    line_end = 1'b0; mem_ack = 1'b0; mem_data = 8'h00; lastAddr = 16'h0000;
    tick();
    tick();
    checkOutput("rstReq", {31'd0, mem_req}, 32'd0);
    checkOutput("rstAddr", {16'd0, mem_addr}, 32'd0);
    checkOutput("rstDlPtr", {16'd0, dl_ptr}, 32'd0);
    checkOutput("rstOffset", {28'd0, line_offset}, 32'd0);
    checkOutput("rstFlags", {26'd0, holey16, holey8, dl_valid, dli_req, late_fetch, 1'b0}, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] basic zone fetch at 0x1800");
    dma_en = 1'b1; ZP = 16'h1800;
    addrQ.push_back(16'h1800); addrQ.push_back(16'h1801); addrQ.push_back(16'h1802);
    applyStimulus(1'b1, 1'b0);
    serveEntry(8'h82, 8'h40, 8'h00, 2, 1'b0);
    mem_ack = 1'b1; mem_data = 8'hEE;
    tick();
    mem_ack = 1'b0;
    checkOutput("strayAckValid", {31'd0, dl_valid}, 32'd0);
    checkOutput("strayAckOffset", {28'd0, line_offset}, 32'd2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("offsetDec1", {28'd0, line_offset}, 32'd1);
    checkOutput("waitNoReq", {31'd0, mem_req}, 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("offsetDec0", {28'd0, line_offset}, 32'd0);
    checkOutput("dliAtZero", {31'd0, dli_req}, 32'd1);
    addrQ.push_back(16'h1803); addrQ.push_back(16'h1804); addrQ.push_back(16'h1805);
    applyStimulus(1'b0, 1'b1);
    checkOutput("dliPulseEnd", {31'd0, dli_req}, 32'd0);
    checkOutput("refetchReq", {31'd0, mem_req}, 32'd1);

    $display("[TB] DLI entry with offset 0");
    serveEntry(8'h80, 8'h50, 8'h10, 0, 1'b0);
    addrQ.push_back(16'h1806); addrQ.push_back(16'h1807); addrQ.push_back(16'h1808);
    applyStimulus(1'b0, 1'b1);
    checkOutput("fetchOnFirstLine", {31'd0, mem_req}, 32'd1);
    serveEntry(8'h63, 8'hAB, 8'hCD, 1, 1'b0);

    $display("[TB] address wrap from 0xFFFE");
    ZP = 16'hFFFE;
    addrQ.push_back(16'hFFFE); addrQ.push_back(16'hFFFF); addrQ.push_back(16'h0000);
    applyStimulus(1'b1, 1'b0);
    serveEntry(8'h01, 8'h12, 8'h34, 0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wrapOffset", {28'd0, line_offset}, 32'd0);
    addrQ.push_back(16'h0001);
    applyStimulus(1'b0, 1'b1);
    expectRequest();

    $display("[TB] late fetch with two line ends");
    ZP = 16'h2400;
    addrQ.push_back(16'h2400); addrQ.push_back(16'h2401); addrQ.push_back(16'h2402);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lateClearedStart", {31'd0, late_fetch}, 32'd0);
    serveEntry(8'h02, 8'h60, 8'h00, 10, 1'b1);
    checkOutput("lateSet", {31'd0, late_fetch}, 32'd1);
    tick();
    checkOutput("pendingApplied", {28'd0, line_offset}, 32'd1);
    tick();
    checkOutput("secondDropped", {28'd0, line_offset}, 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("lateOffset0", {28'd0, line_offset}, 32'd0);
    checkOutput("lateSticky", {31'd0, late_fetch}, 32'd1);

    $display("[TB] frame_start abort and DMA disable");
    ZP = 16'h3000;
    addrQ.push_back(16'h3000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lateClearedFs", {31'd0, late_fetch}, 32'd0);
    serveRead(8'h05, 1, 1'b0);
    checkOutput("fetch1Addr", {16'd0, mem_addr}, 32'h3001);
    ZP = 16'h2000;
    applyStimulus(1'b1, 1'b0);
    checkOutput("abortReq", {31'd0, mem_req}, 32'd1);
    checkOutput("abortAddr", {16'd0, mem_addr}, 32'h2000);
    addrQ.push_back(16'h2000); addrQ.push_back(16'h2001); addrQ.push_back(16'h2002);
    serveEntry(8'h07, 8'h70, 8'h80, 0, 1'b0);
    ZP = 16'h2100;
    addrQ.push_back(16'h2100);
    applyStimulus(1'b1, 1'b0);
    serveRead(8'h01, 0, 1'b0);
    dma_en = 1'b0;
    tick();
    checkOutput("dmaOffReq", {31'd0, mem_req}, 32'd0);
    checkOutput("dmaOffAddr", {16'd0, mem_addr}, 32'd0);
    checkOutput("dmaOffDlPtr", {16'd0, dl_ptr}, 32'h7080);
    checkOutput("dmaOffOffset", {28'd0, line_offset}, 32'd7);
    dma_en = 1'b1;
    tick();
    checkOutput("idleNoReq", {31'd0, mem_req}, 32'd0);

    $display("[TB] reset during FETCH2");
    ZP = 16'h2200;
    addrQ.push_back(16'h2200); addrQ.push_back(16'h2201); addrQ.push_back(16'h2202);
    applyStimulus(1'b1, 1'b0);
    serveRead(8'hC5, 0, 1'b0);
    serveRead(8'h11, 0, 1'b0);
    expectRequest();
    reset = 1'b1; mem_ack = 1'b1; mem_data = 8'h22;
    tick();
    mem_ack = 1'b0; mem_data = 8'h00;
    checkOutput("midRstReq", {31'd0, mem_req}, 32'd0);
    checkOutput("midRstAddr", {16'd0, mem_addr}, 32'd0);
    checkOutput("midRstDlPtr", {16'd0, dl_ptr}, 32'd0);
    checkOutput("midRstOffset", {28'd0, line_offset}, 32'd0);
    checkOutput("midRstFlags", {26'd0, holey16, holey8, dl_valid, dli_req, late_fetch, 1'b0}, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("postRstReq", {31'd0, mem_req}, 32'd0);

    checkOutput("addrQEmpty", addrQ.size(), 32'd0);
    checkOutput("loadQEmpty", loadQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
